// File: rtl/dist_pkg.sv
// dist_pkg: shared FSM state type, default sizing and widths
// for the distance_arbiter block and its sub-modules.
package dist_pkg;
  localparam int NREQ_DEF = 4;
  localparam int ITER_DEF = 3;
  localparam int DIST_W   = 32;
  localparam int SQ_W     = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;
endpackage

// File: rtl/distance_arbiter_if.sv
// distance_arbiter_if: request side (valid/ready + packed coords)
// and result side (valid/ready + data/id); master drives requests.
interface distance_arbiter_if import dist_pkg::*; #(
  parameter int NREQ = NREQ_DEF
) ();
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_x1;
  logic [8*NREQ-1:0] req_y1;
  logic [8*NREQ-1:0] req_x2;
  logic [8*NREQ-1:0] req_y2;
  logic              res_valid;
  logic              res_ready;
  logic [DIST_W-1:0] res_data;
  logic [IDW-1:0]    res_id;

  modport master (
    output req_valid, req_x1, req_y1, req_x2, req_y2,
    output res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_x1, req_y1, req_x2, req_y2,
    input  res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/distance_newton_step.sv
// distance_newton_step: one integer Newton sqrt step (sq, cur) -> nxt.
// Holds 0 when cur is 0; the single shared divider lives here.
module distance_newton_step import dist_pkg::*; (
  input  logic [SQ_W-1:0]   sq,
  input  logic [DIST_W-1:0] cur,
  output logic [DIST_W-1:0] nxt
);
  logic [DIST_W-1:0] den;
  logic [DIST_W-1:0] quo;
  logic [DIST_W-1:0] sum;

  always_comb begin
    // divisor forced to 1 for cur==0 so the divider never sees zero
    den = (cur == '0) ? DIST_W'(1) : cur;
    quo = DIST_W'(sq) / den;
    sum = cur + quo;
    nxt = (cur == '0) ? '0 : (sum >> 1);
  end
endmodule

// File: rtl/distance_arbiter.sv
// distance_arbiter: round-robin arbiter feeding one Euclidean distance
// engine (Newton sqrt); ports: clk, rst_n, bus (distance_arbiter_if.slave).
module distance_arbiter import dist_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int ITER = ITER_DEF
) (
  input logic               clk,
  input logic               rst_n,
  distance_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
  localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

  state_t            state;
  state_t            state_n;
  logic [IDW-1:0]    last_grant;
  logic [IDW-1:0]    gnt;
  logic [IDW-1:0]    id_q;
  logic              any_req;
  logic              accept;
  logic [7:0]        x1, y1, x2, y2;
  logic [7:0]        xd, yd;
  logic [SQ_W-1:0]   sq;
  logic [SQ_W-1:0]   sq_c;
  logic [DIST_W-1:0] cur;
  logic [DIST_W-1:0] cur_nxt;
  logic [2:0]        cnt;

  // search starts one past the previous winner
  always_comb begin : rr_pick
    int idx;
    idx     = 0;
    gnt     = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any_req && bus.req_valid[idx]) begin
        gnt     = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign accept = rst_n && (state == S_IDLE) && any_req;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt] = 1'b1;
  end

  always_comb begin
    xd   = (x1 > x2) ? (x1 - x2) : (x2 - x1);
    yd   = (y1 > y2) ? (y1 - y2) : (y2 - y1);
    sq_c = SQ_W'(16'(xd) * 16'(xd))
         + SQ_W'(16'(yd) * 16'(yd));
  end

  distance_newton_step u_step (
    .sq  (sq),
    .cur (cur),
    .nxt (cur_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = S_LOAD;
      S_LOAD: state_n = S_ITER;
      S_ITER: if (cnt == CNT_LAST) state_n = S_DONE;
      S_DONE: if (bus.res_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= LAST_RST;
      id_q       <= '0;
      x1         <= '0;
      y1         <= '0;
      x2         <= '0;
      y2         <= '0;
      sq         <= '0;
      cur        <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            x1         <= bus.req_x1[8*int'(gnt) +: 8];
            y1         <= bus.req_y1[8*int'(gnt) +: 8];
            x2         <= bus.req_x2[8*int'(gnt) +: 8];
            y2         <= bus.req_y2[8*int'(gnt) +: 8];
            id_q       <= gnt;
            last_grant <= gnt;
          end
        end
        S_LOAD: begin
          sq  <= sq_c;
          cur <= DIST_W'(xd) + DIST_W'(yd);
          cnt <= '0;
        end
        S_ITER: begin
          cur <= cur_nxt;
          cnt <= (cnt == CNT_LAST) ? 3'd0 : cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.res_valid = (state == S_DONE);
  assign bus.res_data  = cur;
  assign bus.res_id    = id_q;
endmodule

// File: tb/tb_distance_arbiter.sv
// tb_distance_arbiter: directed + randomized checks of distance_arbiter
// against a plain-arithmetic Newton/round-robin reference model.
module tb_distance_arbiter;
  import dist_pkg::*;

  localparam int N  = 4;
  localparam int IT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          m_last = N - 1;
  int          g_last = -1;
  logic [31:0] d_last = '0;

  distance_arbiter_if #(.NREQ(N)) bus ();

  distance_arbiter #(.NREQ(N), .ITER(IT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int unsigned ref_dist(input int a, input int b,
                                           input int c, input int d);
    int unsigned dx, dy, sq, cur;
    dx  = (a > c) ? a - c : c - a;
    dy  = (b > d) ? b - d : d - b;
    sq  = dx * dx + dy * dy;
    cur = dx + dy;
    for (int i = 0; i < IT; i++) begin
      if (cur != 0) cur = (cur + sq / cur) / 2;
    end
    return cur;
  endfunction

  task automatic set_xy(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    bus.req_x1[8*i +: 8] = a;
    bus.req_y1[8*i +: 8] = b;
    bus.req_x2[8*i +: 8] = c;
    bus.req_y2[8*i +: 8] = d;
  endtask

  task automatic rand_xy();
    for (int i = 0; i < N; i++)
      set_xy(i, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // one full transaction; coords for the winner must be set by the caller
  task automatic xact(input logic [N-1:0] mask, input int stall,
                      input bit hold);
    int g, n, lat;
    logic [7:0] a, b, c, d;
    logic [31:0] e;
    g = exp_grant(m_last, mask);
    bus.req_valid = mask;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_wait", n, 0);
    chk("grant_onehot", 32'(bus.req_ready), 32'(1 << g));
    a = bus.req_x1[8*g +: 8];
    b = bus.req_y1[8*g +: 8];
    c = bus.req_x2[8*g +: 8];
    d = bus.req_y2[8*g +: 8];
    e = ref_dist(a, b, c, d);
    m_last = g;
    g_last = g;
    @(negedge clk);
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      bus.req_valid = N'($urandom);
      rand_xy();
      #1;
      chk("busy_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, IT + 2);
    chk("res_data", bus.res_data, e);
    chk("res_id", 32'(bus.res_id), g);
    d_last = bus.res_data;
    for (int s = 0; s < stall; s++) begin
      bus.res_ready = 1'b0;
      bus.req_valid = mask;
      @(negedge clk);
      #1;
      chk("stall_valid", 32'(bus.res_valid), 1);
      chk("stall_data", bus.res_data, e);
      chk("stall_id", 32'(bus.res_id), g);
      chk("stall_ready", 32'(bus.req_ready), 0);
    end
    bus.req_valid = hold ? mask : '0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("post_valid", 32'(bus.res_valid), 0);
  endtask

  initial begin
    bit seen;
    int n;
    bus.req_valid = '1;
    bus.res_ready = 1'b0;
    rand_xy();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_data", bus.res_data, 0);
    chk("rst_id", 32'(bus.res_id), 0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_no_req", 32'(bus.req_ready), 0);
    @(negedge clk);

    // (0,0)-(3,4) from requester 0
    set_xy(0, 8'd0, 8'd0, 8'd3, 8'd4);
    xact(4'b0001, 0, 0);
    chk("r0_dist", d_last, 5);
    chk("r0_id", g_last, 0);

    // (255,255)-(0,0) from requester 2
    set_xy(2, 8'd255, 8'd255, 8'd0, 8'd0);
    xact(4'b0100, 0, 0);
    chk("r2_dist", d_last, 360);
    chk("r2_id", g_last, 2);

    // coincident points, result held for 3 stalled cycles
    set_xy(1, 8'd17, 8'd17, 8'd17, 8'd17);
    xact(4'b0010, 3, 0);
    chk("r1_dist", d_last, 0);

    // fresh reset, then all requesters hold valid
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1;
    @(negedge clk);
    rand_xy();
    for (int i = 0; i < 5; i++) begin
      xact(4'b1111, 0, 1);
      chk("rr_order", g_last, i % N);
    end
    bus.req_valid = '0;
    @(negedge clk);

    // reset during the second ITER cycle
    set_xy(3, 8'd10, 8'd20, 8'd200, 8'd90);
    bus.req_valid = 4'b1000;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_accept", 32'(bus.req_ready), 32'(4'b1000));
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_data", bus.res_data, 0);
    chk("mid_rst_id", 32'(bus.res_id), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    chk("no_stale", 32'(seen), 0);
    rand_xy();
    xact(4'b1111, 0, 0);
    chk("rst_first_grant", g_last, 0);

    // randomized masks, coords and stalls
    repeat (30) begin
      rand_xy();
      xact(N'($urandom_range(1, 15)), $urandom_range(0, 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/distance_arbiter.md
DISTANCE_ARBITER -- requirements
Module: distance_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the distance engine (2..8).
REQ-002 Parameter ITER, default 3, number of Newton square-root iterations (1..7).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_x1, req_y1, req_x2, req_y2  input  8*NREQ each  packed coordinates; requester i uses bits [8i+7:8i].
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  downstream accepts result.
REQ-010 res_data  output  32  integer distance, unsigned.
REQ-011 res_id  output  clog2(NREQ)  index of the requester that owns res_data.

Function
REQ-012 The FSM SHALL have four states: IDLE, LOAD, ITER, DONE.
REQ-013 IDLE: if any req_valid is high, assert req_ready for the granted index g only; the transfer completes on the edge where req_valid[g] and req_ready[g] are both high.
REQ-014 Grant SHALL be round-robin: search starts at last_grant+1 modulo NREQ; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-015 On accept: latch the coordinates of g, latch res_id=g, update last_grant=g, and move to LOAD.
REQ-016 LOAD (1 cycle): xd=|x1-x2|, yd=|y1-y2| (8-bit unsigned); sq=xd*xd+yd*yd; cur=xd+yd, zero-extended to 32 bits; then move to ITER with the iteration counter at 0.
REQ-017 ITER (ITER cycles): each cycle, cur <= (cur + sq/cur) >> 1, using unsigned truncating division; after ITER updates, move to DONE.
REQ-018 If cur==0 (coincident points), the iteration SHALL hold cur at 0 and never divide by zero.
REQ-019 DONE: res_valid=1 and res_data=cur; on res_valid and res_ready both high, move to IDLE.
REQ-020 res_valid SHALL rise exactly ITER+2 cycles after the accept edge (5 cycles at default).
REQ-021 Outputs res_data and res_id SHALL stay stable while res_valid=1 and res_ready=0.
REQ-022 req_ready SHALL be 0 in LOAD, ITER and DONE; the earliest next accept is the cycle after the result handshake.
REQ-023 Changes to req_valid or the coordinates after accept SHALL NOT affect an in-flight computation.
REQ-024 The sq width SHALL be at least 17 bits; the worst case is 130050, which fits without overflow.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, req_ready=0, res_valid=0, res_data=0, res_id=0, last_grant=NREQ-1, iteration counter=0.
REQ-026 Reset asserted in any state, including mid-ITER or DONE, SHALL abort the computation; no res_valid follows it.
REQ-027 req_ready SHALL be 0 during reset and in the first cycle is a function of IDLE state and req_valid only.

Structure
REQ-028 Package dist_pkg SHALL hold the state enum, the default NREQ and ITER values, and the 32-bit distance width constant.
REQ-029 One combinational sub-module, distance_newton_step, SHALL take (sq, cur) and return the next cur, including the cur==0 guard.
REQ-030 Only one divider SHALL be instantiated; it is shared by all requesters.

Verification
REQ-031 Requester 0 sends (0,0)-(3,4) -> res_valid 5 cycles after accept, res_data=5, res_id=0.
REQ-032 Requester 2 sends (255,255)-(0,0) -> iterates 510, 382, 361, 360; res_data=360, res_id=2.
REQ-033 Requester 1 sends (17,17)-(17,17) -> res_data=0; no X values and no divide-by-zero.
REQ-034 All four requesters hold req_valid with res_ready=1 -> grant order 0,1,2,3,0, and each grant is one cycle after the previous result handshake.
REQ-035 res_ready is held low for 3 cycles in DONE -> res_valid, res_data and res_id stay constant and req_ready stays 0; normal operation resumes after the handshake.
REQ-036 rst_n is pulled low during the second ITER cycle, then released -> all outputs read reset values, no stale result appears, and the next grant goes to requester 0.
